// File: rtl/code_patch_pkg.sv
// rtl/code_patch_pkg.sv - shared constants, FSM state and entry type for the code-patch register file
package code_patch_pkg;

  localparam logic [7:0] IDX_CTRL       = 8'h00;
  localparam logic [7:0] IDX_PEN        = 8'h01;
  localparam logic [7:0] IDX_NOPG       = 8'h02;
  localparam logic [7:0] IDX_TABLE_BASE = 8'h10;

  localparam int CTRL_PAT_GEN      = 0;
  localparam int CTRL_ADDR_OR_DATA = 1;
  localparam int CTRL_COMMIT       = 2;
  localparam int CTRL_LOCK         = 3;
  localparam int CTRL_DIRTY        = 15;

  localparam int PATCH_ADDR_WIDTH = 32;
  localparam int PATCH_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [PATCH_ADDR_WIDTH-1:0] addr;
    logic [PATCH_DATA_WIDTH-1:0] data;
  } patch_entry_t;

endpackage

// File: rtl/code_patch_regs_entry.sv
// rtl/code_patch_regs_entry.sv - one shadow/active patch entry with per-word, per-lane writes
// Words 0..W-1 hold the address, W..2W-1 the data; bits beyond each field read 0.
module code_patch_regs_entry
  import code_patch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int PDATA_WIDTH = 32,
  parameter int W           = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_we,
  input  logic [7:0]              i_word,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_sel,
  input  logic                    i_commit,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [PDATA_WIDTH-1:0]  o_data
);

  logic [ADDR_WIDTH-1:0]  r_sh_addr, r_act_addr;
  logic [PDATA_WIDTH-1:0] r_sh_data, r_act_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sh_addr  <= '0;
      r_sh_data  <= '0;
      r_act_addr <= '0;
      r_act_data <= '0;
    end else begin
      if (i_we) begin
        for (int b = 0; b < ADDR_WIDTH; b++)
          if (32'(i_word) == 32'(b / DATA_WIDTH) && i_sel[(b % DATA_WIDTH) / 8])
            r_sh_addr[b] <= i_wdata[b % DATA_WIDTH];
        for (int b = 0; b < PDATA_WIDTH; b++)
          if (32'(i_word) == 32'(W + b / DATA_WIDTH) && i_sel[(b % DATA_WIDTH) / 8])
            r_sh_data[b] <= i_wdata[b % DATA_WIDTH];
      end
      if (i_commit) begin
        r_act_addr <= r_sh_addr;
        r_act_data <= r_sh_data;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int b = 0; b < ADDR_WIDTH; b++)
      if (32'(i_word) == 32'(b / DATA_WIDTH)) o_rdata[b % DATA_WIDTH] = r_sh_addr[b];
    for (int b = 0; b < PDATA_WIDTH; b++)
      if (32'(i_word) == 32'(W + b / DATA_WIDTH)) o_rdata[b % DATA_WIDTH] = r_sh_data[b];
  end

  assign o_addr = r_act_addr;
  assign o_data = r_act_data;

endmodule

// File: rtl/code_patch_regs.sv
// rtl/code_patch_regs.sv - Wishbone register file with shadow/active code-patch table and atomic commit
// Optional feature: CODE_PATCH_REGS_LOCK_EN adds a sticky CTRL LOCK bit that rejects all writes.
module code_patch_regs
  import code_patch_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 16,
  parameter int NUM_REGS            = 2,
  parameter int SEL_WIDTH           = DATA_WIDTH / 8,
  parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [DATA_WIDTH-1:0]                        wb_dat_i,
  input  logic [ADDR_WIDTH-1:0]                        wb_adr_i,
  input  logic                                         wb_cyc_i,
  input  logic                                         wb_stb_i,
  input  logic                                         wb_we_i,
  input  logic [SEL_WIDTH-1:0]                         wb_sel_i,
  output logic [DATA_WIDTH-1:0]                        wb_dat_o,
  output logic                                         wb_ack_o,
  output logic                                         wb_err_o,
  output logic                                         wb_stall_o,
  output logic                                         cfg_pat_gen_o,
  output logic                                         cfg_addr_or_data_o,
  output logic [NUM_REGS-1:0][ADDR_WIDTH-1:0]          ctl_pat_addr_o,
  output logic [NUM_REGS-1:0][SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_o,
  output logic [NUM_REGS-1:0]                          ctl_pat_pen_o,
  output logic [NUM_REGS-1:0]                          ctl_pat_nopg_o,
  output logic                                         commit_o
);

  localparam int W               = (SUB_REGS_DATA_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int WORDS_PER_ENTRY = 2 * W;
  localparam int TABLE_WORDS     = WORDS_PER_ENTRY * NUM_REGS;
  localparam int SEL_LSB         = $clog2(SEL_WIDTH);

  wb_state_e             r_state, w_next;
  logic [7:0]            w_idx, w_off, w_ent, w_word;
  logic                  w_req, w_is_ctrl, w_is_pen, w_is_nopg, w_is_table, w_is_shadow;
  logic                  w_lock, w_lock_err, w_err, w_wr, w_ctrl_wr, w_commit;
  logic [DATA_WIDTH-1:0] w_rdata, r_rdata;
  logic                  r_err, r_pat_gen, r_aod, r_dirty, r_commit;
  logic [NUM_REGS-1:0]   r_sh_pen, r_sh_nopg, r_pen, r_nopg, w_ent_we;
  logic [DATA_WIDTH-1:0] w_ent_rdata [NUM_REGS];
  logic                  w_unused_adr;

  assign w_unused_adr = &{1'b0, wb_adr_i};
  assign w_idx        = wb_adr_i[SEL_LSB +: 8];
  assign w_off        = w_idx - IDX_TABLE_BASE;
  assign w_ent        = w_off / 8'(WORDS_PER_ENTRY);
  assign w_word       = w_off % 8'(WORDS_PER_ENTRY);
  assign w_is_ctrl    = (w_idx == IDX_CTRL);
  assign w_is_pen     = (w_idx == IDX_PEN);
  assign w_is_nopg    = (w_idx == IDX_NOPG);
  assign w_is_table   = (w_idx >= IDX_TABLE_BASE) && (32'(w_off) < 32'(TABLE_WORDS));
  assign w_is_shadow  = w_is_pen | w_is_nopg | w_is_table;
  assign w_req        = (r_state == ST_IDLE) & wb_cyc_i & wb_stb_i;

`ifdef CODE_PATCH_REGS_LOCK_EN
  logic r_lock;
  always_ff @(posedge clk_i) begin
    if (rst_i)                                  r_lock <= 1'b0;
    else if (w_ctrl_wr && wb_dat_i[CTRL_LOCK])  r_lock <= 1'b1;
  end
  assign w_lock     = r_lock;
  assign w_lock_err = r_lock & wb_we_i;
`else
  assign w_lock     = 1'b0;
  assign w_lock_err = 1'b0;
`endif

  assign w_err     = ~(w_is_ctrl | w_is_shadow) | w_lock_err;
  assign w_wr      = w_req & wb_we_i & ~w_err;
  assign w_ctrl_wr = w_wr & w_is_ctrl & wb_sel_i[0];
  assign w_commit  = w_ctrl_wr & wb_dat_i[CTRL_COMMIT];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      w_ent_we[i] = w_wr & w_is_table & (w_ent == 8'(i));
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_ctrl) begin
      w_rdata[CTRL_PAT_GEN]      = r_pat_gen;
      w_rdata[CTRL_ADDR_OR_DATA] = r_aod;
      w_rdata[CTRL_LOCK]         = w_lock;
      w_rdata[CTRL_DIRTY]        = r_dirty;
    end else if (w_is_pen) begin
      for (int j = 0; j < NUM_REGS; j++)
        if (j < DATA_WIDTH) w_rdata[j] = r_sh_pen[j];
    end else if (w_is_nopg) begin
      for (int j = 0; j < NUM_REGS; j++)
        if (j < DATA_WIDTH) w_rdata[j] = r_sh_nopg[j];
    end else if (w_is_table) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_ent == 8'(i)) w_rdata = w_ent_rdata[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Response is withdrawn if the master drops cyc or reset hits during RESP.
  always_comb begin
    wb_stall_o = (r_state == ST_RESP);
    wb_ack_o   = wb_stall_o & wb_cyc_i & ~rst_i & ~r_err;
    wb_err_o   = wb_stall_o & wb_cyc_i & ~rst_i &  r_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_pat_gen <= 1'b0;
      r_aod     <= 1'b0;
      r_dirty   <= 1'b0;
      r_commit  <= 1'b0;
      r_sh_pen  <= '0;
      r_sh_nopg <= '0;
      r_pen     <= '0;
      r_nopg    <= '0;
    end else begin
      r_commit <= w_commit;
      if (w_req) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
      if (w_ctrl_wr) begin
        r_pat_gen <= wb_dat_i[CTRL_PAT_GEN];
        r_aod     <= wb_dat_i[CTRL_ADDR_OR_DATA];
      end
      if (w_commit) begin
        r_pen   <= r_sh_pen;
        r_nopg  <= r_sh_nopg;
        r_dirty <= 1'b0;
      end else if (w_wr && w_is_shadow) begin
        r_dirty <= 1'b1;
      end
      for (int j = 0; j < NUM_REGS; j++) begin
        if (j < DATA_WIDTH && wb_sel_i[j / 8]) begin
          if (w_wr && w_is_pen)  r_sh_pen[j]  <= wb_dat_i[j];
          if (w_wr && w_is_nopg) r_sh_nopg[j] <= wb_dat_i[j];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    code_patch_regs_entry #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .PDATA_WIDTH(SUB_REGS_DATA_WIDTH),
      .W          (W)
    ) u_entry (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_we    (w_ent_we[i]),
      .i_word  (w_word),
      .i_wdata (wb_dat_i),
      .i_sel   (wb_sel_i),
      .i_commit(w_commit),
      .o_rdata (w_ent_rdata[i]),
      .o_addr  (ctl_pat_addr_o[i]),
      .o_data  (ctl_pat_data_o[i])
    );
  end

  assign wb_dat_o           = r_rdata;
  assign cfg_pat_gen_o      = r_pat_gen;
  assign cfg_addr_or_data_o = r_aod;
  assign ctl_pat_pen_o      = r_pen;
  assign ctl_pat_nopg_o     = r_nopg;
  assign commit_o           = r_commit;

endmodule

// File: tb/tb_code_patch_regs.sv
// tb/tb_code_patch_regs.sv - self-checking bench for code_patch_regs with a word-level reference model
module tb_code_patch_regs;
  import code_patch_pkg::*;

  localparam int AW = 32, DW = 16, NR = 2, SW = 2, PW = 32;

  logic                       clk = 1'b0, rst_i = 1'b1;
  logic [DW-1:0]              wb_dat_i = '0, wb_dat_o;
  logic [AW-1:0]              wb_adr_i = '0;
  logic                       wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [SW-1:0]              wb_sel_i = '0;
  logic                       wb_ack_o, wb_err_o, wb_stall_o, cfg_pat_gen_o, cfg_addr_or_data_o, commit_o;
  logic [NR-1:0][AW-1:0]      ctl_pat_addr_o;
  logic [NR-1:0][PW-1:0]      ctl_pat_data_o;
  logic [NR-1:0]              ctl_pat_pen_o, ctl_pat_nopg_o;

  int n_checks = 0, n_pass = 0;

  patch_entry_t m_sh [NR], m_act [NR];
  logic [NR-1:0] m_sh_pen, m_sh_nopg, m_act_pen, m_act_nopg;
  logic          m_pg, m_aod, m_dirty, m_lock;

  code_patch_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_dat_i(wb_dat_i), .wb_adr_i(wb_adr_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
    .cfg_pat_gen_o(cfg_pat_gen_o), .cfg_addr_or_data_o(cfg_addr_or_data_o),
    .ctl_pat_addr_o(ctl_pat_addr_o), .ctl_pat_data_o(ctl_pat_data_o),
    .ctl_pat_pen_o(ctl_pat_pen_o), .ctl_pat_nopg_o(ctl_pat_nopg_o), .commit_o(commit_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_sh[i] = '0; m_act[i] = '0;
    end
    m_sh_pen = '0; m_sh_nopg = '0; m_act_pen = '0; m_act_nopg = '0;
    m_pg = 0; m_aod = 0; m_dirty = 0; m_lock = 0;
  endtask

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                             input logic [1:0] sel);
    logic [15:0] m;
    m = {{8{sel[1]}}, {8{sel[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Reference behaviour: decides the response and updates the model for one transfer.
  task automatic model_access(input logic we, input logic [7:0] idx, input logic [15:0] d,
                              input logic [1:0] sel, output logic e_err,
                              output logic [15:0] e_rd, output logic e_commit);
    int e, k;
    logic mapped;
    logic [15:0] wv;
    mapped   = (idx <= 8'd2) || (idx >= 8'h10 && idx < 8'(16 + 4 * NR));
    e_err    = !mapped || (we && m_lock);
    e_rd     = 16'h0;
    e_commit = 1'b0;
    e = (int'(idx) - 16) / 4;
    k = (int'(idx) - 16) % 4;
    if (!e_err && !we) begin
      if (idx == 0)      e_rd = {m_dirty, 11'h0, m_lock, 1'b0, m_aod, m_pg};
      else if (idx == 1) e_rd = 16'(m_sh_pen);
      else if (idx == 2) e_rd = 16'(m_sh_nopg);
      else if (k < 2)    e_rd = 16'(m_sh[e].addr >> (16 * k));
      else               e_rd = 16'(m_sh[e].data >> (16 * (k - 2)));
    end else if (!e_err && we) begin
      if (idx == 0) begin
        if (sel[0]) begin
          m_pg = d[0]; m_aod = d[1];
`ifdef CODE_PATCH_REGS_LOCK_EN
          if (d[3]) m_lock = 1'b1;
`endif
          if (d[2]) begin
            for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
            m_act_pen = m_sh_pen; m_act_nopg = m_sh_nopg;
            m_dirty = 1'b0; e_commit = 1'b1;
          end
        end
      end else begin
        m_dirty = 1'b1;
        if (idx == 1) m_sh_pen = NR'(lane_merge(16'(m_sh_pen), d, sel));
        else if (idx == 2) m_sh_nopg = NR'(lane_merge(16'(m_sh_nopg), d, sel));
        else if (k < 2) begin
          wv = lane_merge(16'(m_sh[e].addr >> (16 * k)), d, sel);
          m_sh[e].addr = (m_sh[e].addr & ~(32'hFFFF << (16 * k))) | (32'(wv) << (16 * k));
        end else begin
          wv = lane_merge(16'(m_sh[e].data >> (16 * (k - 2))), d, sel);
          m_sh[e].data = (m_sh[e].data & ~(32'hFFFF << (16 * (k - 2)))) | (32'(wv) << (16 * (k - 2)));
        end
      end
    end
  endtask

  // One bus transfer; a missing response within the bound leaves ack=err=0.
  task automatic xfer(input logic we, input logic [7:0] idx, input logic [15:0] d,
                      input logic [1:0] sel, output logic ack, output logic err,
                      output logic [15:0] rd, output logic cm);
    int n;
    @(negedge clk);
    n = 0;
    while (wb_stall_o && n < 8) begin @(negedge clk); n++; end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = 32'(idx) << 1; wb_dat_i = d; wb_sel_i = sel;
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    ack = 0; err = 0; rd = '0; cm = commit_o;
    for (int t = 0; t < 4; t++) begin
      if (wb_ack_o || wb_err_o) begin
        ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0;
  endtask

  task automatic test_reset();
    logic ack, err, cm;
    logic [15:0] rd;
    logic [7:0] idxs [3];
    idxs[0] = 8'h00; idxs[1] = 8'h01; idxs[2] = 8'h10;
    do_reset();
    n_checks++;
    if ({ctl_pat_addr_o, ctl_pat_data_o, ctl_pat_pen_o, ctl_pat_nopg_o, cfg_pat_gen_o,
         cfg_addr_or_data_o, commit_o, wb_ack_o, wb_err_o, wb_stall_o} !== '0)
      $display("FAIL reset_outputs: some output nonzero after reset, required all 0");
    else n_pass++;
    foreach (idxs[i]) begin
      xfer(1'b0, idxs[i], 16'h0, 2'b11, ack, err, rd, cm);
      n_checks++;
      if ({ack, err, rd} !== {1'b1, 1'b0, 16'h0})
        $display("FAIL reset_read[%h]: ack=%b err=%b data=%h, required ack=1 err=0 data=0000",
                 idxs[i], ack, err, rd);
      else n_pass++;
    end
  endtask

  task automatic test_commit();
    logic ack, err, cm;
    logic [15:0] rd;
    xfer(1'b1, 8'h14, 16'h5678, 2'b11, ack, err, rd, cm);
    xfer(1'b1, 8'h15, 16'h1234, 2'b11, ack, err, rd, cm);
    xfer(1'b1, 8'h01, 16'h0002, 2'b11, ack, err, rd, cm);
    n_checks++;
    if (ctl_pat_addr_o[1] !== 32'h0 || ctl_pat_pen_o !== 2'b00)
      $display("FAIL pre_commit_active: addr1=%h pen=%b, required 00000000 / 00",
               ctl_pat_addr_o[1], ctl_pat_pen_o);
    else n_pass++;
    xfer(1'b0, 8'h00, 16'h0, 2'b11, ack, err, rd, cm);
    n_checks++;
    if (rd !== 16'h8000) $display("FAIL dirty_set: ctrl=%h, required 8000", rd);
    else n_pass++;
    xfer(1'b1, 8'h00, 16'h0004, 2'b11, ack, err, rd, cm);
    n_checks++;
    if (cm !== 1'b1 || ack !== 1'b1) $display("FAIL commit_pulse: commit=%b ack=%b, required 1/1", cm, ack);
    else n_pass++;
    n_checks++;
    if (ctl_pat_addr_o[1] !== 32'h12345678 || ctl_pat_pen_o !== 2'b10 || commit_o !== 1'b0)
      $display("FAIL post_commit_active: addr1=%h pen=%b commit=%b, required 12345678 / 10 / 0",
               ctl_pat_addr_o[1], ctl_pat_pen_o, commit_o);
    else n_pass++;
    xfer(1'b0, 8'h00, 16'h0, 2'b11, ack, err, rd, cm);
    n_checks++;
    if (rd !== 16'h0000) $display("FAIL dirty_clear: ctrl=%h, required 0000", rd);
    else n_pass++;
  endtask

  task automatic test_byte_sel();
    logic ack, err, cm;
    logic [15:0] rd;
    xfer(1'b1, 8'h16, 16'hABCD, 2'b10, ack, err, rd, cm);
    xfer(1'b0, 8'h16, 16'h0, 2'b11, ack, err, rd, cm);
    n_checks++;
    if (rd !== 16'hAB00) $display("FAIL byte_sel: data=%h, required AB00", rd);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    logic ack, err, cm;
    logic [15:0] rd;
    xfer(1'b1, 8'h80, 16'hFFFF, 2'b11, ack, err, rd, cm);
    n_checks++;
    if ({ack, err} !== 2'b01) $display("FAIL unmapped_write: ack=%b err=%b, required 0/1", ack, err);
    else n_pass++;
    xfer(1'b1, 8'h03, 16'hFFFF, 2'b11, ack, err, rd, cm);
    n_checks++;
    if ({ack, err} !== 2'b01) $display("FAIL unmapped_gap: ack=%b err=%b, required 0/1", ack, err);
    else n_pass++;
    xfer(1'b0, 8'h01, 16'h0, 2'b11, ack, err, rd, cm);
    n_checks++;
    if ({ack, err, rd} !== {2'b10, 16'h0002})
      $display("FAIL after_unmapped: ack=%b err=%b pen=%h, required 1/0/0002", ack, err, rd);
    else n_pass++;
  endtask

  task automatic test_lock();
    logic ack, err, cm;
    logic [15:0] rd;
    do_reset();
    xfer(1'b1, 8'h00, 16'h0008, 2'b11, ack, err, rd, cm);
    xfer(1'b1, 8'h01, 16'h0003, 2'b11, ack, err, rd, cm);
`ifdef CODE_PATCH_REGS_LOCK_EN
    n_checks++;
    if ({ack, err} !== 2'b01) $display("FAIL locked_write: ack=%b err=%b, required 0/1", ack, err);
    else n_pass++;
    xfer(1'b0, 8'h01, 16'h0, 2'b11, ack, err, rd, cm);
    n_checks++;
    if (rd !== 16'h0000) $display("FAIL locked_pen: pen=%h, required 0000", rd);
    else n_pass++;
    do_reset();
    xfer(1'b1, 8'h01, 16'h0003, 2'b11, ack, err, rd, cm);
`endif
    n_checks++;
    if ({ack, err} !== 2'b10) $display("FAIL unlocked_write: ack=%b err=%b, required 1/0", ack, err);
    else n_pass++;
    xfer(1'b0, 8'h01, 16'h0, 2'b11, ack, err, rd, cm);
    n_checks++;
    if (rd !== 16'h0003) $display("FAIL unlocked_pen: pen=%h, required 0003", rd);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic ack, err, cm;
    logic [15:0] rd;
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h2; wb_sel_i = 2'b11;
    @(posedge clk); #1;
    wb_stb_i = 0; rst_i = 1;
    #1;
    n_checks++;
    if ({wb_ack_o, wb_err_o} !== 2'b00)
      $display("FAIL reset_in_resp: ack=%b err=%b, required 0/0", wb_ack_o, wb_err_o);
    else n_pass++;
    @(posedge clk); #1;
    rst_i = 0; wb_cyc_i = 0;
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h2; wb_dat_i = 16'h0001;
    @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    #1;
    n_checks++;
    if ({wb_ack_o, wb_err_o} !== 2'b00)
      $display("FAIL cyc_drop: ack=%b err=%b, required 0/0", wb_ack_o, wb_err_o);
    else n_pass++;
    @(posedge clk); #1;
    xfer(1'b0, 8'h01, 16'h0, 2'b11, ack, err, rd, cm);
    n_checks++;
    if (rd !== 16'h0001) $display("FAIL cyc_drop_written: pen=%h, required 0001", rd);
    else n_pass++;
  endtask

  task automatic test_random();
    logic ack, err, cm, we, e_err, e_cm;
    logic [15:0] rd, d, e_rd;
    logic [1:0] sel;
    logic [7:0] idx;
    int r;
    do_reset();
    model_reset();
    for (int it = 0; it < 120; it++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 2)      idx = 8'(r);
      else if (r <= 8) idx = 8'(16 + $urandom_range(0, 4 * NR - 1));
      else             idx = 8'($urandom_range(0, 255));
      we  = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      sel = 2'($urandom_range(0, 3));
      if (idx == 0) d[3] = 1'b0;
      model_access(we, idx, d, sel, e_err, e_rd, e_cm);
      xfer(we, idx, d, sel, ack, err, rd, cm);
      n_checks++;
      if ({ack, err, cm} !== {!e_err, e_err, e_cm})
        $display("FAIL rand_resp[%0d] idx=%h we=%b: ack=%b err=%b commit=%b, required %b/%b/%b",
                 it, idx, we, ack, err, cm, !e_err, e_err, e_cm);
      else n_pass++;
      if (!we && !e_err) begin
        n_checks++;
        if (rd !== e_rd) $display("FAIL rand_read[%0d] idx=%h: data=%h, required %h", it, idx, rd, e_rd);
        else n_pass++;
      end
      n_checks++;
      if (ctl_pat_pen_o !== m_act_pen || ctl_pat_nopg_o !== m_act_nopg ||
          cfg_pat_gen_o !== m_pg || cfg_addr_or_data_o !== m_aod)
        $display("FAIL rand_cfg[%0d]: pen=%b nopg=%b pg=%b aod=%b, required %b %b %b %b", it,
                 ctl_pat_pen_o, ctl_pat_nopg_o, cfg_pat_gen_o, cfg_addr_or_data_o,
                 m_act_pen, m_act_nopg, m_pg, m_aod);
      else n_pass++;
      for (int i = 0; i < NR; i++) begin
        n_checks++;
        if (ctl_pat_addr_o[i] !== m_act[i].addr || ctl_pat_data_o[i] !== m_act[i].data)
          $display("FAIL rand_entry[%0d][%0d]: addr=%h data=%h, required %h %h", it, i,
                   ctl_pat_addr_o[i], ctl_pat_data_o[i], m_act[i].addr, m_act[i].data);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_byte_sel();
    test_unmapped();
    test_abort();
    test_lock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
